// File: rtl/pc_sequencer_if.sv
// Bus between the pipeline control logic and the next-PC sequencer.
// Signal names keep the sequencer's point of view (_i into it, _o out of it).
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             stall_i;
    logic             imem_ready_i;
    logic             branch_valid_i;
    logic             branch_taken_i;
    logic [31:0]      branch_pc4_i;
    logic [15:0]      branch_imm_i;
    logic             jump_valid_i;
    logic [31:0]      jump_pc4_i;
    logic [25:0]      jump_addr_i;
    logic             jr_valid_i;
    logic [31:0]      jr_target_i;
    logic [31:0]      pc_o;
    logic [31:0]      pc_plus4_o;
    logic             flush_if_o;
    logic             flush_id_o;
    logic             misalign_o;
    logic [CNT_W-1:0] redirect_cnt_o;

    modport master (
        output stall_i, imem_ready_i, branch_valid_i, branch_taken_i,
               branch_pc4_i, branch_imm_i, jump_valid_i, jump_pc4_i,
               jump_addr_i, jr_valid_i, jr_target_i,
        input  pc_o, pc_plus4_o, flush_if_o, flush_id_o, misalign_o,
               redirect_cnt_o
    );

    modport slave (
        input  stall_i, imem_ready_i, branch_valid_i, branch_taken_i,
               branch_pc4_i, branch_imm_i, jump_valid_i, jump_pc4_i,
               jump_addr_i, jr_valid_i, jr_target_i,
        output pc_o, pc_plus4_o, flush_if_o, flush_id_o, misalign_o,
               redirect_cnt_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC, arbitrates branch/JR/J redirects,
// absorbs instruction-memory wait states and freezes on a misaligned JR.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Larger value wins; a pending redirect is only replaced by one of equal or higher rank.
    localparam logic [1:0] PRIO_NONE = 2'd0;
    localparam logic [1:0] PRIO_J    = 2'd1;
    localparam logic [1:0] PRIO_JR   = 2'd2;
    localparam logic [1:0] PRIO_BR   = 2'd3;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_pend_pc;
    logic [1:0]       r_pend_prio;
    logic             r_misalign;
    logic [CNT_W-1:0] r_cnt;

    logic             w_br_take;
    logic [31:0]      w_btarget;
    logic [31:0]      w_jtarget;
    logic [1:0]       w_req_prio;
    logic [31:0]      w_req_target;
    logic             w_req;
    logic             w_accept;
    logic             w_misjr;
    logic             w_cnt_max;

    assign w_br_take = bus.branch_valid_i & bus.branch_taken_i;
    assign w_btarget = bus.branch_pc4_i + {{14{bus.branch_imm_i[15]}}, bus.branch_imm_i, 2'b00};
    assign w_jtarget = {bus.jump_pc4_i[31:28], bus.jump_addr_i, 2'b00};

    // Pick the highest-priority redirect presented this cycle.
    always_comb begin
        w_req_prio   = PRIO_NONE;
        w_req_target = 32'h0000_0000;
        if (w_br_take) begin
            w_req_prio   = PRIO_BR;
            w_req_target = w_btarget;
        end else if (bus.jr_valid_i) begin
            w_req_prio   = PRIO_JR;
            w_req_target = bus.jr_target_i;
        end else if (bus.jump_valid_i) begin
            w_req_prio   = PRIO_J;
            w_req_target = w_jtarget;
        end else begin
            w_req_prio   = PRIO_NONE;
            w_req_target = 32'h0000_0000;
        end
    end

    assign w_req = (w_req_prio != PRIO_NONE);

    // Decide whether the presented redirect is taken in the current state.
    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            ST_RUN:  w_accept = w_req;
            ST_PEND: w_accept = w_req & (w_req_prio >= r_pend_prio);
            default: w_accept = 1'b0;
        endcase
    end

    assign w_misjr   = w_accept & (w_req_prio == PRIO_JR) & (bus.jr_target_i[1:0] != 2'b00);
    assign w_cnt_max = &r_cnt;

    // Flushes are gated by reset so they read low while rst_i is asserted.
    assign bus.flush_if_o     = w_accept & rst_i;
    assign bus.flush_id_o     = w_accept & (w_req_prio == PRIO_BR) & rst_i;
    assign bus.pc_o           = r_pc;
    assign bus.pc_plus4_o     = r_pc + 32'd4;
    assign bus.misalign_o     = r_misalign;
    assign bus.redirect_cnt_o = r_cnt;

    // Redirect counter, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_accept && !w_cnt_max) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // PC state machine: RUN / PENDING (target parked during wait states) / ERR.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_pend_pc   <= 32'h0000_0000;
            r_pend_prio <= PRIO_NONE;
            r_misalign  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_misjr) begin
                        r_state    <= ST_ERR;
                        r_misalign <= 1'b1;
                    end else if (w_accept) begin
                        if (bus.imem_ready_i) begin
                            r_pc <= w_req_target;
                        end else begin
                            r_pend_pc   <= w_req_target;
                            r_pend_prio <= w_req_prio;
                            r_state     <= ST_PEND;
                        end
                    end else if (!bus.stall_i && bus.imem_ready_i) begin
                        r_pc <= r_pc + 32'd4;
                    end else begin
                        r_pc <= r_pc;
                    end
                end
                ST_PEND: begin
                    if (w_misjr) begin
                        r_state     <= ST_ERR;
                        r_misalign  <= 1'b1;
                        r_pend_prio <= PRIO_NONE;
                    end else if (w_accept) begin
                        if (bus.imem_ready_i) begin
                            r_pc        <= w_req_target;
                            r_pend_prio <= PRIO_NONE;
                            r_state     <= ST_RUN;
                        end else begin
                            r_pend_pc   <= w_req_target;
                            r_pend_prio <= w_req_prio;
                        end
                    end else if (bus.imem_ready_i) begin
                        r_pc        <= r_pend_pc;
                        r_pend_prio <= PRIO_NONE;
                        r_state     <= ST_RUN;
                    end else begin
                        r_pc <= r_pc;
                    end
                end
                ST_ERR: begin
                    r_pc <= r_pc;
                end
                default: begin
                    r_state <= ST_ERR;
                end
            endcase
        end
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the pipelined MIPS core. It owns the fetch PC register and selects the sequential path, the EX-stage branch target, or an ID-stage J/JR target. Branch offsets are sign-extended and shifted left two; J targets are PC-region concatenated and shifted left two. It also generates IF/ID flush pulses, handles instruction-memory wait states and stalls, and counts redirects.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset.
CNT_W, 16, width of the saturating redirect counter.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous active-low reset.
stall_i  input  1  hazard-unit stall; hold the PC.
imem_ready_i  input  1  instruction memory accepts pc_o this cycle.
branch_valid_i  input  1  a branch is resolved in EX this cycle.
branch_taken_i  input  1  the resolved branch is taken.
branch_pc4_i  input  32  PC+4 of the EX-stage branch.
branch_imm_i  input  16  branch immediate.
jump_valid_i  input  1  J/JAL decoded in ID.
jump_pc4_i  input  32  PC+4 of the ID-stage jump.
jump_addr_i  input  26  J-format target field.
jr_valid_i  input  1  JR decoded in ID.
jr_target_i  input  32  register target for JR.
pc_o  output  32  current fetch PC (registered).
pc_plus4_o  output  32  pc_o + 4, combinational, wraps mod 2^32.
flush_if_o  output  1  invalidate the IF/ID register.
flush_id_o  output  1  invalidate the ID/EX register.
misalign_o  output  1  sticky: JR target had bits [1:0] != 0.
redirect_cnt_o  output  CNT_W  number of accepted redirects, saturating.

Behaviour:
- Reset (rst_i=0, asynchronous): pc_o=RESET_PC, state=RUN, pending register=0, misalign_o=0, redirect_cnt_o=0, flush_if_o=0, flush_id_o=0.
- Target arithmetic, all mod 2^32:
  - btarget = branch_pc4_i + {{14{imm[15]}}, imm, 2'b00}
  - jtarget = {jump_pc4_i[31:28], jump_addr_i, 2'b00}
  - rtarget = jr_target_i
- Redirect priority, highest first:
  - branch (branch_valid_i & branch_taken_i)
  - JR
  - J
  - stall
  - sequential
  - A branch overrides a simultaneous JR/J; the younger ID instruction is flushed.
- Flushes (combinational, asserted in the cycle the redirect is accepted):
  - Branch: flush_if_o=1 and flush_id_o=1.
  - J/JR: flush_if_o=1 only.
  - Redirects override stall_i; flushes are still asserted while stalled.
- States:
  - RUN:
    - Redirect with imem_ready_i=1: pc_o<=target next edge, counter increments.
    - Redirect with imem_ready_i=0: latch the target into the pending register, go to PENDING, counter increments, flush still asserted.
    - No redirect, stall_i=0, imem_ready_i=1: pc_o<=pc_o+4.
    - Otherwise: hold.
  - PENDING:
    - pc_o holds.
    - When imem_ready_i=1: pc_o<=pending, go to RUN.
    - A new higher-or-equal-priority redirect in PENDING replaces the pending target, counts, and flushes per its type.
    - stall_i is ignored for leaving PENDING.
  - ERR:
    - Entered when an accepted JR has rtarget[1:0]!=0; misalign_o<=1.
    - pc_o is frozen at its value at entry and all redirects are ignored.
    - Flushes stay 0, except flush_if_o is asserted in the entry cycle.
    - Exit only via reset.
- Latency: a redirect accepted in cycle N appears on pc_o in cycle N+1 when memory is ready.
- redirect_cnt_o saturates at 2^CNT_W-1 and never wraps.
- Reset mid-PENDING discards the pending target.
- A PC wrap from 32'hFFFF_FFFC goes to 0.

Test Plan:
- Reset release, no stalls, imem_ready_i=1 -> pc_o sequence 0,4,8,C; pc_plus4_o=pc_o+4; no flushes.
- Taken branch: branch_pc4_i=32'h100, imm=16'hFFFE, with jump_valid_i=1 in the same cycle -> flush_if_o=flush_id_o=1 for one cycle; next pc_o=32'hF8; counter=1.
- J with jump_pc4_i=32'h4000_0010, jump_addr_i=26'h0000040 -> flush_if_o=1, flush_id_o=0; next pc_o=32'h4000_0100.
- Redirect during imem_ready_i=0 for 3 cycles, branch target 32'h200 -> pc_o holds 3 cycles, then becomes 32'h200 on the first ready edge; a stall during PENDING does not block it.
- JR to 32'h0000_0102 -> misalign_o=1; pc_o frozen; a subsequent branch is ignored; reset clears misalign_o and pc_o returns to RESET_PC.
- Counter with CNT_W=2 and 5 redirects -> redirect_cnt_o=3; async reset asserted mid-cycle -> outputs clear immediately.
